// File: rtl/seq_sub32_pkg.sv
// rtl/seq_sub32_pkg.sv - shared constants, state type and parameter check for seq_sub32
package seq_sub32_pkg;

    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic bit digit_w_legal(input int w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8) || (w == 16) || (w == 32);
    endfunction

endpackage

// File: rtl/seq_sub32_digit.sv
// rtl/seq_sub32_digit.sv - combinational DIGIT_W-bit borrow-ripple subtract slice
module sub_digit #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               bin,
    output logic [DIGIT_W-1:0] diff,
    output logic               bout
);

    // a - b - bin == a + ~b + ~bin: full-adder chain with the borrow carried inverted
    logic [DIGIT_W-1:0] b_n;
    logic [DIGIT_W:0]   carry;

    assign b_n      = ~b;
    assign carry[0] = ~bin;

    for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
        assign diff[i]    = a[i] ^ b_n[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b_n[i]) | (carry[i] & (a[i] ^ b_n[i]));
    end

    assign bout = ~carry[DIGIT_W];

endmodule

// File: rtl/seq_sub32.sv
// rtl/seq_sub32.sv - multi-cycle 32-bit subtractor, DIGIT_W bits per clock, start/busy/done
module seq_sub32
    import seq_sub32_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] input_a,
    input  logic [DATA_W-1:0] input_b,
    input  logic              bin,
    output logic [DATA_W-1:0] sub_result,
    output logic              bout,
    output logic              overflow,
    output logic              zero,
    output logic              busy,
    output logic              done
);

    localparam int NDIG  = DATA_W / DIGIT_W;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    if (!digit_w_legal(DIGIT_W)) begin : g_bad_digit_w
        $error("seq_sub32: DIGIT_W must be one of 1, 2, 4, 8, 16, 32");
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, part_q, part_d;
    logic              borrow_q, borrow_d;
    logic              a_sign_q, a_sign_d, b_sign_q, b_sign_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d, done_q, done_d;

    logic [DIGIT_W-1:0] dig_diff;
    logic               dig_bout;
    logic [DATA_W-1:0]  part_shift;

    sub_digit #(.DIGIT_W(DIGIT_W)) u_digit (
        .a    (a_sh_q[DIGIT_W-1:0]),
        .b    (b_sh_q[DIGIT_W-1:0]),
        .bin  (borrow_q),
        .diff (dig_diff),
        .bout (dig_bout)
    );

    // Digits enter at the top so the first (least significant) one lands at bit 0 after NDIG shifts
    if (DIGIT_W == DATA_W) begin : g_single
        assign part_shift = dig_diff;
    end else begin : g_multi
        assign part_shift = {dig_diff, part_q[DATA_W-1:DIGIT_W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            part_q   <= '0;
            borrow_q <= 1'b0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            res_q    <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            part_q   <= part_d;
            borrow_q <= borrow_d;
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            res_q    <= res_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        part_d   = part_q;
        borrow_d = borrow_q;
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        res_d    = res_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        if (state_q == IDLE && start) begin
            a_sh_d   = input_a;
            b_sh_d   = input_b;
            borrow_d = bin;
            cnt_d    = '0;
            part_d   = '0;
            // Sign bits are kept separately because the operand registers shift away
            a_sign_d = input_a[DATA_W-1];
            b_sign_d = input_b[DATA_W-1];
        end else if (state_q == RUN) begin
            a_sh_d   = a_sh_q >> DIGIT_W;
            b_sh_d   = b_sh_q >> DIGIT_W;
            borrow_d = dig_bout;
            part_d   = part_shift;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                res_d  = part_shift;
                bout_d = dig_bout;
                ovf_d  = (a_sign_q != b_sign_q) && (part_shift[DATA_W-1] != a_sign_q);
                zero_d = (part_shift == '0);
                done_d = 1'b1;
            end
        end
    end

    always_comb begin
        busy       = (state_q == RUN);
        done       = done_q;
        sub_result = res_q;
        bout       = bout_q;
        overflow   = ovf_q;
        zero       = zero_q;
    end

endmodule

// File: tb/tb_seq_sub32.sv
// tb/tb_seq_sub32.sv - self-checking bench for seq_sub32 at DIGIT_W = 4, 1 and 32
module tb_seq_sub32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        bin = 1'b0;
    logic [31:0] input_a = '0;
    logic [31:0] input_b = '0;

    logic [2:0][31:0] res;
    logic [2:0]       bo, ov, zr, bsy, dn;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_r4 = '0;

    always #5 clk = ~clk;

    seq_sub32 #(.DIGIT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .input_a(input_a), .input_b(input_b), .bin(bin),
        .sub_result(res[0]), .bout(bo[0]), .overflow(ov[0]), .zero(zr[0]), .busy(bsy[0]), .done(dn[0])
    );
    seq_sub32 #(.DIGIT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .input_a(input_a), .input_b(input_b), .bin(bin),
        .sub_result(res[1]), .bout(bo[1]), .overflow(ov[1]), .zero(zr[1]), .busy(bsy[1]), .done(dn[1])
    );
    seq_sub32 #(.DIGIT_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .input_a(input_a), .input_b(input_b), .bin(bin),
        .sub_result(res[2]), .bout(bo[2]), .overflow(ov[2]), .zero(zr[2]), .busy(bsy[2]), .done(dn[2])
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bi;
        logic [31:0] r;
        logic        bo;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t vt[8];

    function automatic int ndig(input int i);
        case (i)
            0:       return 8;
            1:       return 32;
            default: return 1;
        endcase
    endfunction

    function automatic int dw(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            default: return 32;
        endcase
    endfunction

    // Reference: plain 33-bit arithmetic; returns {borrow, overflow, zero, result}
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic bi);
        logic [32:0] d;
        logic        o;
        d = {1'b0, a} - {1'b0, b} - {32'd0, bi};
        o = (a[31] != b[31]) && (d[31] != a[31]);
        return {d[32], o, (d[31:0] == 32'd0), d[31:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (bsy == 3'b000) begin
                ok = 1;
                break;
            end
        end
        check("wait_idle", ok, 1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bi,
                         input logic [31:0] er, input logic eb, input logic eo, input logic ez);
        int lat[3];
        int cnt[3];
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0;
            cnt[i] = 0;
        end
        @(negedge clk);
        input_a = a;
        input_b = b;
        bin     = bi;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        input_a = $urandom;
        input_b = $urandom;
        bin     = 1'($urandom_range(0, 1));
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 2) begin
                check("w4_hold_mid_op", res[0], last_r4);
                check("w4_busy_mid_op", {31'd0, bsy[0]}, 32'd1);
            end
            for (int i = 0; i < 3; i++) begin
                if (dn[i]) begin
                    cnt[i]++;
                    if (lat[i] == 0) lat[i] = c;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("w%0d_latency a=%h b=%h", dw(i), a, b), lat[i], ndig(i) + 1);
            check($sformatf("w%0d_done_count", dw(i)), cnt[i], 1);
            check($sformatf("w%0d_result a=%h b=%h bin=%0d", dw(i), a, b, bi), res[i], er);
            check($sformatf("w%0d_flags {bout,ovf,zero}", dw(i)),
                  {29'd0, bo[i], ov[i], zr[i]}, {29'd0, eb, eo, ez});
        end
        last_r4 = er;
    endtask

    initial begin
        logic [34:0] m;
        logic [31:0] ra, rb;
        logic        rbi;
        int          found;
        int          c9;
        int          dcount;

        vt[0] = '{32'h0000000A, 32'h00000003, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0};
        vt[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vt[2] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vt[3] = '{32'h00000005, 32'h00000004, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vt[4] = '{32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vt[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};
        vt[6] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vt[7] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("w%0d_reset_result", dw(i)), res[i], 32'd0);
            check($sformatf("w%0d_reset_flags", dw(i)),
                  {27'd0, bo[i], ov[i], zr[i], bsy[i], dn[i]}, 32'd0);
        end
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++)
            do_op(vt[v].a, vt[v].b, vt[v].bi, vt[v].r, vt[v].bo, vt[v].ov, vt[v].z);

        for (int n = 0; n < 20; n++) begin
            ra  = $urandom;
            rb  = (n % 4 == 0) ? ra : $urandom;
            rbi = 1'($urandom_range(0, 1));
            m   = model(ra, rb, rbi);
            do_op(ra, rb, rbi, m[31:0], m[34], m[33], m[32]);
        end

        // start while busy is ignored, then start held in the done cycle is accepted
        @(negedge clk);
        input_a = 32'h10;
        input_b = 32'h01;
        bin     = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        input_a = 32'h0;
        input_b = 32'h0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dn[0]) begin
                found = 1;
                break;
            end
        end
        check("w4_busy_ignore_done_seen", found, 1);
        check("w4_busy_ignore_result", res[0], 32'h0000000F);
        input_a = 32'h20;
        input_b = 32'h01;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        c9 = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (dn[0]) begin
                c9 = c;
                break;
            end
        end
        check("w4_back_to_back_spacing", c9, 9);
        check("w4_back_to_back_result", res[0], 32'h0000001F);
        last_r4 = 32'h0000001F;
        wait_idle();

        // asynchronous reset three cycles into RUN
        @(negedge clk);
        input_a = 32'h10;
        input_b = 32'h01;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("w%0d_midrun_reset_result", dw(i)), res[i], 32'd0);
            check($sformatf("w%0d_midrun_reset_flags", dw(i)),
                  {27'd0, bo[i], ov[i], zr[i], bsy[i], dn[i]}, 32'd0);
        end
        dcount = 0;
        repeat (2) begin
            @(negedge clk);
            if (dn != 3'b000) dcount++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (dn != 3'b000) dcount++;
        end
        check("no_done_after_midrun_reset", dcount, 0);
        last_r4 = 32'd0;
        do_op(32'h0000000A, 32'h00000003, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_sub32.md
Name: seq_sub32

Overview:
- Multi-cycle 32-bit subtractor for the datapath; the inverse of the ripple adder.
- Computes input_a - input_b - bin, DIGIT_W bits per clock, through a start/busy/done handshake.
- Gives a low-area subtract/compare path for SUB, SUBU and SLT-style flag generation when the datapath moves to multi-cycle.
- Produces result, borrow-out, signed-overflow and zero flags, all registered.

Parameters:
- DIGIT_W, default 4: bits processed per cycle.
  - Legal values: 1, 2, 4, 8, 16, 32.
  - Any other value is an elaboration error.
- NDIG (derived, not overridable): 32/DIGIT_W, the number of processing cycles.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only when busy=0.
- input_a  input  32  minuend; captured at the accepting edge.
- input_b  input  32  subtrahend; captured at the accepting edge.
- bin  input  1  borrow-in; captured at the accepting edge.
- sub_result  output  32  a - b - bin modulo 2^32.
- bout  output  1  unsigned borrow-out: 1 iff a < b + bin.
- overflow  output  1  signed overflow: (a[31]!=b[31]) && (sub_result[31]!=a[31]).
- zero  output  1  1 iff sub_result==0.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when the outputs update.

Behaviour:
- Reset (rst_n low, async): state=IDLE, digit counter=0, internal operand/partial registers=0.
  - sub_result=0, bout=0, overflow=0, zero=0, busy=0, done=0.
  - Deassertion is assumed synchronised externally.
- States:
  - IDLE: busy=0. Edge with start=1 latches input_a, input_b and bin into the shift registers; borrow register=bin; counter=0; go to RUN.
  - RUN: busy=1. Each edge subtracts the low DIGIT_W bits of the a/b shift registers with the running borrow, shifts the difference into the partial result (LSB digit first), updates the borrow, counter+1.
  - On the edge where counter==NDIG-1: write sub_result, bout, overflow and zero from the completed partial and final borrow; done=1 for the following cycle; go to IDLE.
- Latency: accepting edge k means done=1 and new outputs visible in the cycle after edge k+NDIG. NDIG=8 at the default.
- Outputs hold their values from the last completion until the next completion; they never show partial values mid-operation.
- start while busy=1: ignored; latched operands are unaffected.
- Back-to-back: the done cycle has busy=0, so start=1 in that cycle is accepted, giving a new done every NDIG+1 cycles.
- Input changes after the accepting edge have no effect.
- Reset mid-RUN: everything is cleared immediately and no done is emitted.
- overflow is computed from the captured a[31] and b[31]; bin does not enter the formula except via sub_result.
- DIGIT_W=32 case: one RUN cycle; done follows the accepting edge by one cycle.

Decomposition:
- Shared package holds:
  - DATA_W=32.
  - Legal DIGIT_W list and assertion helper.
  - State enum {IDLE, RUN}.
- One natural sub-module, sub_digit: combinational DIGIT_W-bit borrow-ripple slice.
  - Inputs: a, b, bin.
  - Outputs: diff, bout.
  - Built from the team's existing full-adder cell with b inverted and the borrow mapped to inverted carry.
- Top holds the FSM, counter, shift registers and output registers.

Test Plan:
- Default DIGIT_W=4, a=0x0000000A, b=0x00000003, bin=0, start pulse -> busy for 8 cycles, then done=1 once; sub_result=0x00000007, bout=0, overflow=0, zero=0.
- a=0x00000000, b=0x00000001 -> sub_result=0xFFFFFFFF, bout=1, overflow=0, zero=0.
- a=0x80000000, b=0x00000001 -> sub_result=0x7FFFFFFF, overflow=1, bout=0.
- Zero flag:
  - a=0x00000005, b=0x00000004, bin=1 -> sub_result=0, zero=1, bout=0.
  - Then a=0x00000005, b=0x00000005, bin=1 -> sub_result=0xFFFFFFFF, bout=1.
- Busy and back-to-back handling:
  - Start 0x10-0x01; mid-RUN assert start with 0x0-0x0 -> ignored, result 0x0000000F.
  - start held in the done cycle with 0x20-0x01 -> accepted; second done exactly 9 cycles after the first, result 0x0000001F.
- Reset and parameter sweep:
  - rst_n low 3 cycles into RUN -> all outputs 0 at once, no done pulse.
  - After release, a new op completes normally.
  - Repeat the first scenario with DIGIT_W=1 (33-cycle spacing) and DIGIT_W=32 (done one cycle after the accepting edge).
